// File: rtl/spi_sclk_gen_pkg.sv
// Shared types and default widths for the SPI serial-clock generator.
package spi_sclk_gen_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int unsigned DIV_W_DEF = 16;
  localparam int unsigned EC_W_DEF  = 8;

endpackage

// File: rtl/spi_div_counter.sv
// Reloadable down-counter for the SPI clock divider.
// Flags zero; when enabled, it reloads at zero instead of wrapping.
module spi_div_counter
#(
  parameter int unsigned DIV_W = 16
) (
  input  logic             wb_clk,
  input  logic             wb_reset,
  input  logic             load,
  input  logic             en,
  input  logic [DIV_W-1:0] load_val,
  output logic             zero
);

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  logic [DIV_W-1:0] cnt;

  always_ff @(posedge wb_clk or posedge wb_reset) begin
    if (wb_reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en) begin
      if (cnt == '0) cnt <= load_val;
      else           cnt <= cnt - ONE;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/spi_sclk_gen.sv
// SPI serial-clock generator: divides wb_clk, drives sclk and edge strobes.
// Optional edge counter enabled by SPI_SCLK_GEN_EDGE_CNT_EN.
module spi_sclk_gen
  import spi_sclk_gen_pkg::*;
#(
  parameter int unsigned DIV_W = DIV_W_DEF,
  parameter int unsigned EC_W  = EC_W_DEF
) (
  input  logic             wb_clk,
  input  logic             wb_reset,
  input  logic             go,
  input  logic             tip,
  input  logic             lstclk,
  input  logic [DIV_W-1:0] divider,
  input  logic             cpol,
  output logic             sclk,
  output logic             pos_edge,
  output logic             neg_edge,
  output logic             busy
`ifdef SPI_SCLK_GEN_EDGE_CNT_EN
  ,
  output logic [EC_W-1:0]  edge_cnt
`endif
);

  if (DIV_W < 1 || EC_W < 1) begin : g_param_chk
    $error("spi_sclk_gen: DIV_W and EC_W must be at least 1");
  end

  state_t state, state_nx;
  logic   zero;
  logic   cpol_r;
  logic   load, en, toggle;
  logic   sclk_d, pos_d, neg_d;

  spi_div_counter #(
    .DIV_W (DIV_W)
  ) u_div (
    .wb_clk   (wb_clk),
    .wb_reset (wb_reset),
    .load     (load),
    .en       (en),
    .load_val (divider),
    .zero     (zero)
  );

  always_ff @(posedge wb_clk or posedge wb_reset) begin
    if (wb_reset) state <= IDLE;
    else          state <= state_nx;
  end

  // The final toggle back to the idle level leaves RUN on the same edge.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (go && tip) state_nx = RUN;
      RUN: begin
        if (!tip)                                    state_nx = IDLE;
        else if (zero && lstclk && (sclk != cpol_r)) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    load   = (state == IDLE);
    en     = (state == RUN);
    toggle = (state == RUN) && tip && zero;
    sclk_d = sclk;
    if (state == IDLE)  sclk_d = cpol;
    else if (!tip)      sclk_d = cpol_r;
    else if (toggle)    sclk_d = ~sclk;
    pos_d  = toggle && !sclk;
    neg_d  = toggle && sclk;
  end

  always_ff @(posedge wb_clk or posedge wb_reset) begin
    if (wb_reset) begin
      sclk     <= 1'b0;
      pos_edge <= 1'b0;
      neg_edge <= 1'b0;
      cpol_r   <= 1'b0;
    end else begin
      sclk     <= sclk_d;
      pos_edge <= pos_d;
      neg_edge <= neg_d;
      if (state == IDLE) cpol_r <= cpol;
    end
  end

  assign busy = (state == RUN);

`ifdef SPI_SCLK_GEN_EDGE_CNT_EN
  always_ff @(posedge wb_clk or posedge wb_reset) begin
    if (wb_reset) begin
      edge_cnt <= '0;
    end else if ((state == IDLE) && go && tip) begin
      edge_cnt <= '0;
    end else if (toggle && (edge_cnt != '1)) begin
      edge_cnt <= edge_cnt + EC_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_spi_sclk_gen.sv
// Directed self-checking bench for spi_sclk_gen; edge counter checked
// when SPI_SCLK_GEN_EDGE_CNT_EN is defined.
module tb_spi_sclk_gen;

  localparam int unsigned DIV_W = 8;
  localparam int unsigned EC_W  = 2;

  logic             wb_clk;
  logic             wb_reset;
  logic             go, tip, lstclk, cpol;
  logic [DIV_W-1:0] divider;
  logic             sclk, pos_edge, neg_edge, busy;
`ifdef SPI_SCLK_GEN_EDGE_CNT_EN
  logic [EC_W-1:0]  edge_cnt;
`endif

  int n_checks;
  int n_fail;

  spi_sclk_gen #(
    .DIV_W (DIV_W),
    .EC_W  (EC_W)
  ) dut (
    .wb_clk   (wb_clk),
    .wb_reset (wb_reset),
    .go       (go),
    .tip      (tip),
    .lstclk   (lstclk),
    .divider  (divider),
    .cpol     (cpol),
    .sclk     (sclk),
    .pos_edge (pos_edge),
    .neg_edge (neg_edge),
    .busy     (busy)
`ifdef SPI_SCLK_GEN_EDGE_CNT_EN
    ,
    .edge_cnt (edge_cnt)
`endif
  );

  initial wb_clk = 1'b0;
  always #5 wb_clk = ~wb_clk;

  // Advance one edge; outputs are observed 1 time unit after it.
  task automatic tick();
    @(posedge wb_clk);
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] obs;
    wb_reset = 1'b1;
    go = 0; tip = 0; lstclk = 0; cpol = 1'b1; divider = 8'd3;
    tick(); tick();
    wb_reset = 1'b0;
    tick();
    tip = 1; go = 1;
    tick();
    go = 0;
    tick(); tick(); tick();
    #2 wb_reset = 1'b1;
    #1;
    obs = {sclk, pos_edge, neg_edge, busy};
    n_checks++;
    if (obs !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_async_outputs: got %b expected 0000", obs);
    end
    tick();
    obs = {sclk, pos_edge, neg_edge, busy};
    n_checks++;
    if (obs !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_held_outputs: got %b expected 0000", obs);
    end
`ifdef SPI_SCLK_GEN_EDGE_CNT_EN
    n_checks++;
    if (edge_cnt !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_edge_cnt: got %0d expected 0", edge_cnt);
    end
`endif
    tip = 0;
    wb_reset = 1'b0;
    tick();
    obs = {sclk, pos_edge, neg_edge, busy};
    n_checks++;
    if (obs !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_release_idle: got %b expected 1000", obs);
    end
  endtask

  // cpol=0, divider=3: toggles every 4 edges after go, lstclk after 7th strobe.
  task automatic test_divider3();
    logic [3:0] obs, exp_v;
    int strobes;
    strobes = 0;
    cpol = 0; divider = 8'd3; lstclk = 0; tip = 1; go = 0;
    tick();
    go = 1;
    tick();
    go = 0;
    obs = {sclk, pos_edge, neg_edge, busy};
    n_checks++;
    if (obs !== 4'b0001) begin
      n_fail++;
      $display("FAIL div3_go_accept: got %b expected 0001", obs);
    end
    for (int k = 1; k <= 36; k++) begin
      tick();
      exp_v[3] = (k < 32) ? ((k / 4) % 2 == 1) : 1'b0;
      exp_v[2] = (k % 4 == 0) && ((k / 4) % 2 == 1) && (k <= 32);
      exp_v[1] = (k % 4 == 0) && ((k / 4) % 2 == 0) && (k >= 8) && (k <= 32);
      exp_v[0] = (k < 32);
      obs = {sclk, pos_edge, neg_edge, busy};
      if (pos_edge || neg_edge) strobes++;
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL div3_cycle%0d {sclk,pos,neg,busy}: got %b expected %b", k, obs, exp_v);
      end
      if (k == 28) lstclk = 1;
    end
    n_checks++;
    if (strobes != 8) begin
      n_fail++;
      $display("FAIL div3_strobe_count: got %0d expected 8", strobes);
    end
    lstclk = 0; tip = 0;
    tick();
  endtask

  task automatic test_cpol1_div0();
    logic [3:0] obs;
    logic [3:0] exp_t [1:5];
    exp_t[1] = 4'b0011; exp_t[2] = 4'b1101; exp_t[3] = 4'b0011;
    exp_t[4] = 4'b1100; exp_t[5] = 4'b1000;
    cpol = 1; divider = 8'd0; lstclk = 0; tip = 1; go = 0;
    tick();
    go = 1;
    tick();
    go = 0;
    obs = {sclk, pos_edge, neg_edge, busy};
    n_checks++;
    if (obs !== 4'b1001) begin
      n_fail++;
      $display("FAIL div0_go_accept: got %b expected 1001", obs);
    end
    for (int k = 1; k <= 5; k++) begin
      tick();
      obs = {sclk, pos_edge, neg_edge, busy};
      n_checks++;
      if (obs !== exp_t[k]) begin
        n_fail++;
        $display("FAIL div0_cycle%0d {sclk,pos,neg,busy}: got %b expected %b", k, obs, exp_t[k]);
      end
      if (k == 2) lstclk = 1;
    end
    lstclk = 0; tip = 0;
    tick();
  endtask

  task automatic test_abort();
    logic [3:0] obs;
    cpol = 0; divider = 8'd5; lstclk = 0; tip = 0; go = 1;
    tick();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL go_without_tip: got busy=%b expected 0", busy);
    end
    tip = 1;
    tick();
    go = 0;
    for (int k = 1; k <= 8; k++) tick();
    obs = {sclk, pos_edge, neg_edge, busy};
    n_checks++;
    if (obs !== 4'b1001) begin
      n_fail++;
      $display("FAIL abort_before: got %b expected 1001", obs);
    end
    tip = 0;
    tick();
    obs = {sclk, pos_edge, neg_edge, busy};
    n_checks++;
    if (obs !== 4'b0000) begin
      n_fail++;
      $display("FAIL abort_forced_idle: got %b expected 0000", obs);
    end
    tip = 1; go = 1;
    tick();
    go = 0;
    for (int k = 1; k <= 5; k++) tick();
    obs = {sclk, pos_edge, neg_edge, busy};
    n_checks++;
    if (obs !== 4'b0001) begin
      n_fail++;
      $display("FAIL restart_cycle5: got %b expected 0001", obs);
    end
    tick();
    obs = {sclk, pos_edge, neg_edge, busy};
    n_checks++;
    if (obs !== 4'b1101) begin
      n_fail++;
      $display("FAIL restart_first_rise: got %b expected 1101", obs);
    end
    tip = 0;
    tick();
  endtask

  // divider 2 -> 6 changed mid half-period: rise at 3, fall at 6, rise at 13.
  task automatic test_div_change();
    logic [3:0] obs;
    cpol = 0; divider = 8'd2; lstclk = 0; tip = 1; go = 1;
    tick();
    go = 0;
    for (int k = 1; k <= 13; k++) begin
      tick();
      if (k == 4) divider = 8'd6;
      obs = {sclk, pos_edge, neg_edge, busy};
      if (k == 3 || k == 5 || k == 6 || k == 12 || k == 13) begin
        n_checks++;
        if ((k == 3  && obs !== 4'b1101) || (k == 5  && obs !== 4'b1001) ||
            (k == 6  && obs !== 4'b0011) || (k == 12 && obs !== 4'b0001) ||
            (k == 13 && obs !== 4'b1101)) begin
          n_fail++;
          $display("FAIL divchange_cycle%0d {sclk,pos,neg,busy}: got %b (see cycle table 3:1101 5:1001 6:0011 12:0001 13:1101)", k, obs);
        end
      end
    end
    tip = 0;
    tick();
  endtask

`ifdef SPI_SCLK_GEN_EDGE_CNT_EN
  task automatic test_edge_cnt();
    logic [EC_W-1:0] exp_t [1:6];
    exp_t[1] = 2'd1; exp_t[2] = 2'd2; exp_t[3] = 2'd3;
    exp_t[4] = 2'd3; exp_t[5] = 2'd3; exp_t[6] = 2'd3;
    cpol = 0; divider = 8'd0; lstclk = 0; tip = 1; go = 1;
    tick();
    go = 0;
    n_checks++;
    if (edge_cnt !== 2'd0) begin
      n_fail++;
      $display("FAIL ecnt_clear_on_go: got %0d expected 0", edge_cnt);
    end
    for (int k = 1; k <= 6; k++) begin
      tick();
      n_checks++;
      if (edge_cnt !== exp_t[k]) begin
        n_fail++;
        $display("FAIL ecnt_strobe%0d: got %0d expected %0d", k, edge_cnt, exp_t[k]);
      end
    end
    tip = 0;
    tick(); tick();
    n_checks++;
    if (edge_cnt !== 2'd3) begin
      n_fail++;
      $display("FAIL ecnt_hold_idle: got %0d expected 3", edge_cnt);
    end
    tip = 1; go = 1;
    tick();
    go = 0; tip = 0;
    n_checks++;
    if (edge_cnt !== 2'd0) begin
      n_fail++;
      $display("FAIL ecnt_clear_next_go: got %0d expected 0", edge_cnt);
    end
    tick();
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_divider3();
    test_cpol1_div0();
    test_abort();
    test_div_change();
`ifdef SPI_SCLK_GEN_EDGE_CNT_EN
    test_edge_cnt();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
